nibble_serial_add16: RTL
========================

# nibble_serial_add16

Multi-cycle 16-bit adder that feeds the 4-bit carry-lookahead slice one nibble per cycle and accumulates the result. It latches two 16-bit operands on a valid/ready handshake and produces a 16-bit sum with carry, signed-overflow and zero flags after four compute cycles. It sits ahead of the 4-bit adder slice and is used where area matters more than single-cycle latency, such as the multi-cycle execute path. It is the sequencing and carry-chaining front end for the slice.

## Interface
- No parameters; widths fixed (16-bit operand, 4-bit slice).
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand request.
- in_ready  out  1  block idle, can accept.
- a  in  16  operand A.
- b  in  16  operand B.
- cin  in  1  carry into bit 0 (add mode).
- sub  in  1  subtract request (present only with NSA16_SUB_EN).
- out_valid  out  1  result held.
- out_ready  in  1  consumer takes result.
- sum  out  16  result.
- cout  out  1  carry out of bit 15.
- ovf  out  1  signed overflow.
- zero  out  1  sum == 0.

## Operation
- States:
  - IDLE: in_ready=1. Moves to RUN on in_valid & in_ready.
  - RUN: nibble index k=0..3. Moves to DONE after k=3.
  - DONE: out_valid=1. Moves to IDLE on out_ready.
- Accept: latch a, b, cin (and sub) into operand registers. Clear sum register. Set k=0. Inputs may change freely afterwards.
- RUN cycle k: slice gets a_q[4k+3:4k], b_eff[4k+3:4k], and carry c_q (cin_q at k=0). Slice sum is written to sum_q[4k+3:4k]. Slice cout is written to c_q. k increments modulo 4 (2-bit counter, wraps 3→0 on exit).
- Flags are registered at the k=3 edge:
  - cout = final carry.
  - ovf = (a_q[15]==b_eff[15]) & (sum[15]!=a_q[15]).
  - zero = (sum==0).
- sum, cout, ovf and zero are held stable for the whole time out_valid=1, and until the next accept.
- in_ready is high only in IDLE. in_valid is ignored in RUN and DONE. No input queuing.
- out_valid is not withdrawn before the handshake. out_ready is ignored outside DONE.
- Reset values: state IDLE, in_ready=1 from the first cycle after reset, out_valid=0, sum=0, cout=0, ovf=0, zero=0, k=0.
- Reset asserted mid-RUN or in DONE aborts the operation and discards the result. Reset takes precedence over any handshake in the same cycle.

## Timing
- Accept at edge E0. Nibbles 0..3 are registered at E1..E4. out_valid is high from E4: 4-cycle latency.
- out_ready high in the first DONE cycle: handshake at E5, IDLE from E5. Next accept earliest at E6.
- Peak throughput: one operation per 6 cycles.
- Slice is purely combinational between operand/carry registers and sum/carry registers. There is exactly one slice delay plus the mux per cycle.

## Configuration
- NSA16_SUB_EN defined:
  - sub port present.
  - sub=1 gives b_eff = ~b_q and first-nibble carry = 1. cin is ignored.
  - cout=1 means no borrow. ovf follows the same formula using b_eff.
- NSA16_SUB_EN undefined:
  - no sub port.
  - b_eff = b_q and first carry = cin_q (add only).

## Structure
- Shared package nsa16_pkg:
  - state enum (IDLE, RUN, DONE).
  - constants NSA_WIDTH=16, NSA_SLICE=4, NSA_NIBBLES=4.
- One sub-module: the existing combinational cla_4bit slice, instantiated once.
- Nibble muxing, carry register and FSM stay in the top module.

## Test plan
- a=0x00FF, b=0x0001, cin=0 → after 4 cycles sum=0x0100, cout=0, ovf=0, zero=0, out_valid first high at E4.
- a=0xFFFF, b=0x0001, cin=0 → sum=0x0000, cout=1, zero=1, ovf=0. Carry ripples through all four nibbles.
- a=0x7FFF, b=0x0001, cin=0 → sum=0x8000, ovf=1, cout=0.
- Backpressure: out_ready held low for 3 cycles in DONE while in_valid stays high with new operands → sum/flags stable, in_ready=0, no second accept. Raising out_ready gives IDLE, then the second operation is accepted.
- NSA16_SUB_EN: a=0x0005, b=0x0007, sub=1 → sum=0xFFFE, cout=0, ovf=0. With sub=0, cin=1: 0x0005+0x0007 → 0x000D.
- rst pulsed for one cycle at E2 mid-RUN → out_valid stays 0, in_ready=1 the next cycle, a fresh operation completes normally.

Source files
------------

// File: rtl/nsa16_pkg.sv
// Shared types and constants for the nibble-serial 16-bit adder.
package nsa16_pkg;

  localparam int unsigned NSA_WIDTH   = 16;
  localparam int unsigned NSA_SLICE   = 4;
  localparam int unsigned NSA_NIBBLES = NSA_WIDTH / NSA_SLICE;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } nsa_state_e;

endpackage

// File: rtl/cla_4bit.sv
// Combinational 4-bit carry-lookahead adder slice.
module cla_4bit (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       c_i,
  output logic [3:0] sum_o,
  output logic       cout_o
);

  logic [3:0] p;
  logic [3:0] g;
  logic [4:0] c;

  assign p = a_i ^ b_i;
  assign g = a_i & b_i;

  // Carries are flattened lookahead terms, not a ripple chain.
  assign c[0] = c_i;
  assign c[1] = g[0] | (p[0] & c_i);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_i);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_i);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c_i);

  assign sum_o  = p ^ c[3:0];
  assign cout_o = c[4];

endmodule

// File: rtl/nibble_serial_add16.sv
// Multi-cycle 16-bit adder: one 4-bit CLA slice reused over four cycles.
// Optional subtract mode (sub port) is enabled by defining NSA16_SUB_EN.
module nibble_serial_add16
  import nsa16_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NSA_WIDTH-1:0] a,
  input  logic [NSA_WIDTH-1:0] b,
  input  logic                 cin,
`ifdef NSA16_SUB_EN
  input  logic                 sub,
`endif
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NSA_WIDTH-1:0] sum,
  output logic                 cout,
  output logic                 ovf,
  output logic                 zero
);

  localparam int unsigned KW = $clog2(NSA_NIBBLES);
  localparam logic [KW-1:0] KLast = KW'(NSA_NIBBLES - 1);

  nsa_state_e state_q, state_d;

  logic [KW-1:0]        k_q, k_d;
  logic [NSA_WIDTH-1:0] a_q, a_d;
  logic [NSA_WIDTH-1:0] b_q, b_d;
  logic                 cin_q, cin_d;
  logic                 c_q, c_d;
  logic [NSA_WIDTH-1:0] sum_q, sum_d;
  logic                 cout_q, cout_d;
  logic                 ovf_q, ovf_d;
  logic                 zero_q, zero_d;

  logic [NSA_WIDTH-1:0] b_eff;
  logic                 first_carry;
  logic                 accept;
  logic [3:0]           slice_a;
  logic [3:0]           slice_b;
  logic                 slice_c;
  logic [3:0]           slice_sum;
  logic                 slice_cout;

`ifdef NSA16_SUB_EN
  logic sub_q, sub_d;

  // Subtract as a + ~b + 1; cin is ignored while sub is set.
  assign b_eff       = sub_q ? ~b_q : b_q;
  assign first_carry = sub_q ? 1'b1 : cin_q;
`else
  assign b_eff       = b_q;
  assign first_carry = cin_q;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
      c_q     <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
`ifdef NSA16_SUB_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cin_q   <= cin_d;
      c_q     <= c_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
`ifdef NSA16_SUB_EN
      sub_q   <= sub_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (in_valid)     state_d = StRun;
      StRun:   if (k_q == KLast) state_d = StDone;
      StDone:  if (out_ready)    state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
  end

  assign accept = (state_q == StIdle) && in_valid;

  assign slice_a = a_q[{k_q, 2'b00} +: NSA_SLICE];
  assign slice_b = b_eff[{k_q, 2'b00} +: NSA_SLICE];
  assign slice_c = (k_q == '0) ? first_carry : c_q;

  cla_4bit u_slice (
    .a_i    (slice_a),
    .b_i    (slice_b),
    .c_i    (slice_c),
    .sum_o  (slice_sum),
    .cout_o (slice_cout)
  );

  // Datapath: operand capture, nibble write-back and flag update
  always_comb begin
    k_d    = k_q;
    a_d    = a_q;
    b_d    = b_q;
    cin_d  = cin_q;
    c_d    = c_q;
    sum_d  = sum_q;
    cout_d = cout_q;
    ovf_d  = ovf_q;
    zero_d = zero_q;
`ifdef NSA16_SUB_EN
    sub_d  = sub_q;
`endif
    if (accept) begin
      a_d   = a;
      b_d   = b;
      cin_d = cin;
      sum_d = '0;
      k_d   = '0;
`ifdef NSA16_SUB_EN
      sub_d = sub;
`endif
    end else if (state_q == StRun) begin
      sum_d[{k_q, 2'b00} +: NSA_SLICE] = slice_sum;
      c_d = slice_cout;
      k_d = k_q + 1'b1;
      if (k_q == KLast) begin
        cout_d = slice_cout;
        ovf_d  = (a_q[NSA_WIDTH-1] == b_eff[NSA_WIDTH-1]) &&
                 (sum_d[NSA_WIDTH-1] != a_q[NSA_WIDTH-1]);
        zero_d = (sum_d == '0);
      end
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
  assign zero = zero_q;

endmodule
